// File: rtl/issue_ctrl_pkg.sv
// Shared decode/issue package: opcode classes, register address width, scoreboard counter width
// and the latency-to-countdown helper used by the issue controller.
package issue_ctrl_pkg;

  localparam int DEF_REG_ADDRESS_SIZE = 5;
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    OP_RR = 3'd0,
    OP_IR = 3'd1,
    OP_SR = 3'd2,
    OP_LR = 3'd3,
    OP_B  = 3'd4,
    OP_J  = 3'd5
  } opcode_e;

  // Countdown value loaded at issue: the dependent may read once it reaches zero.
  function automatic logic [CNT_W-1:0] lat_m1(input logic load, input int alu_lat,
                                              input int load_lat);
    return load ? CNT_W'(load_lat - 1) : CNT_W'(alu_lat - 1);
  endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard_entry.sv
// One scoreboard counter: cycles until a pending register write becomes readable.
// Loads on issue, otherwise decrements toward zero; frozen while the pipe is stalled.
module scoreboard_entry
  import issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new issue to the same register wins over the decrement in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (load_i)               cnt_d = load_val_i;
      else if (cnt_q != '0)     cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/issue_ctrl.sv
// Scoreboard issue controller: RAW/WAW hold of decode, issue strobe to execute, wrong-path flush.
// Build option ISSUE_CTRL_BYPASS_EN: forwarding present, effective ALU latency 1 and load latency 2.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
  parameter int ALU_LAT          = 3,
  parameter int LOAD_LAT         = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        D_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_r1,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_r2,
  input  logic                        D_use_r1,
  input  logic                        D_use_r2,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_rd,
  input  logic                        D_We,
  input  logic                        D_load,
  input  logic                        D_branch,
  input  logic                        D_stall_in,
  output logic                        D_stall,
  output logic                        E_issue,
  output logic                        F_flush,
  output logic                        busy
);

  localparam int NREG = 1 << REG_ADDRESS_SIZE;

`ifdef ISSUE_CTRL_BYPASS_EN
  localparam int ALU_EFF = 1;
  localparam int LD_EFF  = 2;
`else
  localparam int ALU_EFF = ALU_LAT;
  localparam int LD_EFF  = LOAD_LAT;
`endif

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            nz;
  logic [CNT_W-1:0]           lat_v;
  logic                       rd_nz, wr_en, raw, waw, hazard;

  // x0 is hardwired: no counter, never pending.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  generate
    for (genvar g = 1; g < NREG; g++) begin : g_sb
      scoreboard_entry u_ent (
        .clk        (clk),
        .reset      (reset),
        .freeze_i   (D_stall_in),
        .load_i     (wr_en && (D_addr_rd == REG_ADDRESS_SIZE'(g))),
        .load_val_i (lat_v),
        .cnt_o      (cnt[g]),
        .nz_o       (nz[g])
      );
    end
  endgenerate

  assign lat_v = lat_m1(D_load, ALU_EFF, LD_EFF);
  assign rd_nz = (D_addr_rd != '0);

  assign raw = (D_use_r1 && (D_addr_r1 != '0) && (cnt[D_addr_r1] != '0)) ||
               (D_use_r2 && (D_addr_r2 != '0) && (cnt[D_addr_r2] != '0));
  // WAW only bites when an older, longer write would land after this one.
  assign waw = D_We && rd_nz && (cnt[D_addr_rd] > lat_v);

  assign hazard  = D_valid && (raw || waw);
  assign D_stall = hazard || D_stall_in;
  assign E_issue = D_valid && !hazard && !D_stall_in;
  assign F_flush = E_issue && D_branch;
  assign wr_en   = E_issue && D_We && rd_nz;
  assign busy    = |nz;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: per-cycle expected outputs queued by the driver,
// popped and compared by a negedge monitor.
module tb_issue_ctrl;

  localparam int ALU_LAT  = 3;
  localparam int LOAD_LAT = 4;
`ifdef ISSUE_CTRL_BYPASS_EN
  localparam int AL = 1;
  localparam int LL = 2;
`else
  localparam int AL = ALU_LAT;
  localparam int LL = LOAD_LAT;
`endif

  typedef struct {
    logic       v;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       br;
  } ins_t;

  typedef struct {
    logic  iss;
    logic  stl;
    logic  fl;
    logic  bsy;
    bit    cb;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D_valid = 1'b0, D_use_r1 = 1'b0, D_use_r2 = 1'b0;
  logic [4:0] D_addr_r1 = '0, D_addr_r2 = '0, D_addr_rd = '0;
  logic       D_We = 1'b0, D_load = 1'b0, D_branch = 1'b0, D_stall_in = 1'b0;
  logic       D_stall, E_issue, F_flush, busy;

  exp_t exp_q[$];
  int   n_tot = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.REG_ADDRESS_SIZE(5), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid),
    .D_addr_r1(D_addr_r1), .D_addr_r2(D_addr_r2),
    .D_use_r1(D_use_r1), .D_use_r2(D_use_r2),
    .D_addr_rd(D_addr_rd), .D_We(D_We), .D_load(D_load), .D_branch(D_branch),
    .D_stall_in(D_stall_in), .D_stall(D_stall), .E_issue(E_issue),
    .F_flush(F_flush), .busy(busy)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".issue"}, E_issue, e.iss);
      chk({e.tag, ".stall"}, D_stall, e.stl);
      chk({e.tag, ".flush"}, F_flush, e.fl);
      if (e.cb) chk({e.tag, ".busy"}, busy, e.bsy);
    end
  end

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 1'b0, r1: 5'd0, u1: 1'b0, r2: 5'd0, u2: 1'b0, rd: 5'd0,
          we: 1'b0, ld: 1'b0, br: 1'b0};
    return i;
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs);
    ins_t i;
    i = nop();
    i.v = 1'b1; i.r1 = rs; i.u1 = 1'b1; i.rd = rd; i.we = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs);
    ins_t i;
    i = alu(rd, rs);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t jmp(input logic [4:0] rs);
    ins_t i;
    i = nop();
    i.v = 1'b1; i.r1 = rs; i.u1 = 1'b1; i.br = 1'b1;
    return i;
  endfunction

  task automatic drv(input ins_t i, input logic sin, input logic ei, input logic es,
                     input logic ef, input logic eb, input bit cb, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    D_valid = i.v; D_addr_r1 = i.r1; D_use_r1 = i.u1; D_addr_r2 = i.r2; D_use_r2 = i.u2;
    D_addr_rd = i.rd; D_We = i.we; D_load = i.ld; D_branch = i.br; D_stall_in = sin;
    e = '{iss: ei, stl: es, fl: ef, bsy: eb, cb: cb, tag: tag};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    repeat (8) drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "drain");
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t c;
    // reset state: stall follows stall_in only
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
    drv(nop(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "rst_sin");
    reset = 1'b0;

    // independent back-to-back ALU ops
    drv(alu(5'd1, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ind0");
    drv(alu(5'd2, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, AL > 1, 1'b1, "ind1");
    drv(alu(5'd3, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, AL > 1, 1'b1, "ind2");
    for (int k = 1; k <= AL + 1; k++)
      drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, k < AL, 1'b1, "ind_busy");
    drain();

    // ALU RAW
    drv(alu(5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "raw_p");
    for (int k = 1; k <= AL; k++)
      drv(alu(5'd6, 5'd5), 1'b0, k == AL, k < AL, 1'b0, k < AL, 1'b1, "raw_c");
    drain();

    // load-use via rs2, rs1 reads x0
    drv(lw(5'd7, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "lu_p");
    c = alu(5'd8, 5'd0);
    c.r2 = 5'd7; c.u2 = 1'b1;
    for (int k = 1; k <= LL; k++)
      drv(c, 1'b0, k == LL, k < LL, 1'b0, k < LL, 1'b1, "lu_c");
    drain();

    // WAW: ALU write after a longer load to the same rd
    drv(lw(5'd3, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "waw_p");
    for (int k = 1; k <= LL - AL + 1; k++)
      drv(alu(5'd3, 5'd0), 1'b0, k == LL - AL + 1, k < LL - AL + 1, 1'b0, k < LL, 1'b1,
          "waw_c");
    drain();

    // x0 writes and reads never hazard or occupy the scoreboard
    drv(alu(5'd0, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "x0_w");
    drv(lw(5'd0, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "x0_ww");
    drv(alu(5'd4, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "x0_r");
    drain();

    // downstream freeze during a hazard
    drv(alu(5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "frz_p");
    repeat (3) drv(alu(5'd6, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, AL > 1, 1'b1, "frz_hold");
    for (int u = 1; u <= AL; u++)
      drv(alu(5'd6, 5'd5), 1'b0, u == AL, u < AL, 1'b0, u < AL, 1'b1, "frz_rel");
    drain();

    // jumps: flush only in the issue cycle
    drv(jmp(5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "jmp_frz");
    drv(jmp(5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "jmp0");
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "jmp0_after");
    drv(alu(5'd9, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "jmp_p");
    for (int k = 1; k <= AL; k++)
      drv(jmp(5'd9), 1'b0, k == AL, k < AL, k == AL, k < AL, 1'b1, "jmp_haz");
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "jmp_after");
    drain();

    // reset while a consumer is held
    drv(alu(5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rh_p");
    drv(alu(5'd6, 5'd5), 1'b0, AL == 1, AL > 1, 1'b0, AL > 1, 1'b1, "rh_c");
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rh_rst");
    reset = 1'b1;
    drv(alu(5'd6, 5'd5), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rh_after");
    reset = 1'b0;
    drv(nop(), 1'b0, 1'b0, 1'b0, 1'b0, AL > 1, 1'b1, "rh_new");

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Scoreboard-based issue controller between the decode stage and execute. Tracks outstanding register writes per architectural register, holds decode on RAW/WAW hazards, forwards a registered-free issue strobe to execute, and kills the wrong-path fetch slot after a decode-resolved jump. Sequences the decode datapath; holds no instruction data itself.

## Interface
Parameters:
- REG_ADDRESS_SIZE, 5, register address width (32 registers, x0 hardwired).
- ALU_LAT, 3, cycles from ALU/jump issue until the result is readable by a dependent; 1..8.
- LOAD_LAT, 4, same for loads; ALU_LAT ≤ LOAD_LAT ≤ 8.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- D_valid  in  1  decode holds a valid instruction.
- D_addr_r1, D_addr_r2  in  REG_ADDRESS_SIZE  source registers.
- D_use_r1, D_use_r2  in  1  source actually read.
- D_addr_rd  in  REG_ADDRESS_SIZE  destination.
- D_We  in  1  instruction writes rd.
- D_load  in  1  instruction is a load (LOAD_LAT applies).
- D_branch  in  1  decode-resolved jump.
- D_stall_in  in  1  downstream freeze (memory miss).
- D_stall  out  1  hold fetch/decode this cycle.
- E_issue  out  1  instruction passes to execute this cycle.
- F_flush  out  1  kill the instruction currently in fetch.
- busy  out  1  any scoreboard counter nonzero.

## Operation
- Scoreboard: 31 counters cnt[1..31], 3 bits each; x0 never tracked, reads of x0 never hazard.
- raw = (D_use_r1 & r1≠0 & cnt[r1]≠0) | (D_use_r2 & r2≠0 & cnt[r2]≠0).
- waw = D_We & rd≠0 & cnt[rd] > (lat−1), lat = D_load ? LOAD_LAT : ALU_LAT (ALU after an outstanding longer load to same rd).
- hazard = D_valid & (raw | waw).
- D_stall = hazard | D_stall_in.
- E_issue = D_valid & ~hazard & ~D_stall_in.
- F_flush = E_issue & D_branch.
- Counter update, only when D_stall_in = 0: every nonzero counter decrements by 1; then, if E_issue & D_We & rd≠0, cnt[rd] ← lat−1 (load overrides decrement on the same register).
- D_stall_in = 1: all counters frozen, no issue, no flush.
- busy = OR of all counters.

## Timing
- Reset: all counters 0; outputs follow combinationally from inputs and zeroed counters (D_stall = D_stall_in, busy = 0).
- D_stall, E_issue, F_flush combinational from current inputs and registered counters; counters update at clk edge.
- Producer issuing at cycle t: dependent may issue no earlier than t+lat (unfrozen cycles); back-to-back dependent sees lat−1 stall cycles; lat = 1 never stalls.
- Jump issue at t: F_flush high in t only; fetch slot at t discarded; stalled jump does not flush until it issues.
- reset mid-stall: counters cleared next edge; pending hazards vanish.

## Configuration
- ISSUE_CTRL_BYPASS_EN defined: execute/memory forwarding present; effective ALU latency 1 (no ALU RAW stall), effective load latency 2 (single load-use bubble); WAW rule uses the same effective latencies.
- Undefined: full ALU_LAT / LOAD_LAT applied as above.

## Structure
- Shared pipeline package: opcode constants (RR, IR, SR, LR, B, J), REG_ADDRESS_SIZE, counter width constant.
- One sub-module natural: scoreboard_entry (3-bit countdown with load/decrement/freeze), instantiated 31 times; hazard/issue logic at top level.

## Test plan
- Independent ALU ops x1←, x2← back-to-back -> E_issue every cycle, D_stall 0, busy 1 until 2 cycles after last issue.
- ALU x5← at t, consumer reads x5 at t+1, no bypass -> D_stall at t+1,t+2; E_issue at t+3; with BYPASS_EN issue at t+1.
- Load x7← at t, consumer reads x7 -> issue at t+4 (no bypass), t+2 (BYPASS_EN).
- Load x3← at t, ALU x3← at t+1 -> WAW stall until cnt[x3] ≤ 2, issue at t+2; read of x0 after write to x0 never stalls.
- D_stall_in high 3 cycles during a hazard -> counters frozen, E_issue 0; stall count resumes exactly after release.
- Jump issued at t -> F_flush high only at t; same jump held by hazard -> F_flush 0 until issue; reset asserted mid-hazard -> busy 0 next cycle.
